// File: rtl/line_raster.sv
// Bresenham line rasterizer with an optional repeating dash mask.
// Streams one pixel per handshake and pulses done once the end point is accepted.
module line_raster #(
    parameter int COORD_W   = 16,
    parameter int PATTERN_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [COORD_W-1:0]   x1,
    input  logic [COORD_W-1:0]   y1,
    input  logic [COORD_W-1:0]   x2,
    input  logic [COORD_W-1:0]   y2,
    input  logic [PATTERN_W-1:0] pattern,
    input  logic                 pattern_en,
    input  logic                 pix_ready,
    output logic                 pix_valid,
    output logic [COORD_W-1:0]   pix_x,
    output logic [COORD_W-1:0]   pix_y,
    output logic                 pix_last,
    output logic                 busy,
    output logic                 done
);

    localparam int IDX_W = $clog2(PATTERN_W);
    localparam int E_W   = COORD_W + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [COORD_W-1:0]   r_cur_x;
    logic [COORD_W-1:0]   r_cur_y;
    logic [COORD_W-1:0]   r_x2;
    logic [COORD_W-1:0]   r_y2;
    logic [PATTERN_W-1:0] r_pattern;
    logic                 r_pattern_en;
    logic signed [E_W-1:0] r_dx;
    logic signed [E_W-1:0] r_dy;
    logic signed [E_W-1:0] r_err;
    logic                 r_sx_pos;
    logic                 r_sy_pos;
    logic [IDX_W-1:0]     r_idx;

    logic                 w_x_up;
    logic                 w_y_up;
    logic [COORD_W-1:0]   w_adx;
    logic [COORD_W-1:0]   w_ady;
    logic signed [E_W-1:0] w_dx_init;
    logic signed [E_W-1:0] w_dy_init;
    logic signed [E_W-1:0] w_e2;
    logic                 w_step_x;
    logic                 w_step_y;
    logic signed [E_W-1:0] w_err_next;
    logic                 w_at_end;
    logic                 w_emit;
    logic                 w_advance;

    // Setup terms use the latched start point held in r_cur_x/r_cur_y.
    assign w_x_up    = (r_x2 >= r_cur_x);
    assign w_y_up    = (r_y2 >= r_cur_y);
    assign w_adx     = w_x_up ? (r_x2 - r_cur_x) : (r_cur_x - r_x2);
    assign w_ady     = w_y_up ? (r_y2 - r_cur_y) : (r_cur_y - r_y2);
    assign w_dx_init = {2'b00, w_adx};
    assign w_dy_init = -{2'b00, w_ady};

    assign w_e2       = {r_err[E_W-2:0], 1'b0};
    assign w_step_x   = (w_e2 >= r_dy);
    assign w_step_y   = (w_e2 <= r_dx);
    assign w_err_next = r_err + (w_step_x ? r_dy : '0) + (w_step_y ? r_dx : '0);

    assign w_at_end = (r_cur_x == r_x2) && (r_cur_y == r_y2);
    assign w_emit   = !r_pattern_en || r_pattern[r_idx] || w_at_end;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        w_state_next = r_state;
        w_advance    = 1'b0;
        pix_valid    = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_state_next = S_SETUP;
            end
            S_SETUP: w_state_next = S_RUN;
            S_RUN: begin
                pix_valid = w_emit;
                if (!w_emit) begin
                    w_advance = 1'b1;
                end else if (pix_ready) begin
                    if (w_at_end) w_state_next = S_DONE;
                    else          w_advance    = 1'b1;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Gated by pix_valid: after reset the zeroed registers make cur equal the end point.
    assign pix_last = pix_valid && w_at_end;
    assign pix_x    = r_cur_x;
    assign pix_y    = r_cur_y;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cur_x      <= '0;
            r_cur_y      <= '0;
            r_x2         <= '0;
            r_y2         <= '0;
            r_pattern    <= '0;
            r_pattern_en <= 1'b0;
            r_dx         <= '0;
            r_dy         <= '0;
            r_err        <= '0;
            r_sx_pos     <= 1'b0;
            r_sy_pos     <= 1'b0;
            r_idx        <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cur_x      <= x1;
                        r_cur_y      <= y1;
                        r_x2         <= x2;
                        r_y2         <= y2;
                        r_pattern    <= pattern;
                        r_pattern_en <= pattern_en;
                    end
                end
                S_SETUP: begin
                    r_dx     <= w_dx_init;
                    r_dy     <= w_dy_init;
                    r_err    <= w_dx_init + w_dy_init;
                    r_sx_pos <= w_x_up;
                    r_sy_pos <= w_y_up;
                    r_idx    <= '0;
                end
                S_RUN: begin
                    if (w_advance) begin
                        r_err <= w_err_next;
                        if (w_step_x)
                            r_cur_x <= r_sx_pos ? r_cur_x + COORD_W'(1) : r_cur_x - COORD_W'(1);
                        if (w_step_y)
                            r_cur_y <= r_sy_pos ? r_cur_y + COORD_W'(1) : r_cur_y - COORD_W'(1);
                        r_idx <= (r_idx == IDX_W'(PATTERN_W - 1)) ? '0 : r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_raster.sv
// Randomized and directed bench for line_raster against an integer Bresenham
// reference that produces the expected emitted-pixel list for each line.
module tb_line_raster;

    localparam int CW = 16;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] x1, y1, x2, y2;
    logic [PW-1:0] pattern;
    logic          pattern_en;
    logic          pix_ready;
    logic          pix_valid;
    logic [CW-1:0] pix_x, pix_y;
    logic          pix_last;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    line_raster #(.COORD_W(CW), .PATTERN_W(PW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .x1         (x1),
        .y1         (y1),
        .x2         (x2),
        .y2         (y2),
        .pattern    (pattern),
        .pattern_en (pattern_en),
        .pix_ready  (pix_ready),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_last   (pix_last),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        int x;
        int y;
        int last;
    } pix_t;

    pix_t exp_q[$];
    pix_t got_q[$];
    int   raw_len;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: walk the line with integer Bresenham and keep the pixels the mask lets through.
    task automatic build_expected(input int ax1, input int ay1, input int ax2, input int ay2,
                                  input logic [PW-1:0] pat, input bit pen);
        int dx, dy, sx, sy, err, e2, x, y, i, at_end;
        pix_t p;
        exp_q.delete();
        dx  = (ax2 >= ax1) ? ax2 - ax1 : ax1 - ax2;
        dy  = -((ay2 >= ay1) ? ay2 - ay1 : ay1 - ay2);
        sx  = (ax2 >= ax1) ? 1 : -1;
        sy  = (ay2 >= ay1) ? 1 : -1;
        err = dx + dy;
        x   = ax1;
        y   = ay1;
        i   = 0;
        for (int guard = 0; guard < 200000; guard++) begin
            at_end = (x == ax2 && y == ay2) ? 1 : 0;
            if (!pen || pat[i % PW] || at_end == 1) begin
                p.x = x; p.y = y; p.last = at_end;
                exp_q.push_back(p);
            end
            if (at_end == 1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
            i++;
        end
        raw_len = i + 1;
    endtask

    task automatic run_line(input int ax1, input int ay1, input int ax2, input int ay2,
                            input logic [PW-1:0] pat, input bit pen,
                            input int ready_pct, input int stall_at, input string tag);
        int   cyc, budget, n, adx, ady;
        bit   finished, prev_stall;
        logic [CW-1:0] prev_x, prev_y;
        pix_t p;
        build_expected(ax1, ay1, ax2, ay2, pat, pen);
        got_q.delete();
        @(negedge clk);
        x1 = ax1[CW-1:0]; y1 = ay1[CW-1:0]; x2 = ax2[CW-1:0]; y2 = ay2[CW-1:0];
        pattern = pat; pattern_en = pen; pix_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, ":setup_busy"}, busy, 1);
        check({tag, ":setup_valid"}, pix_valid, 0);
        budget     = 4 * raw_len + 100;
        cyc        = 0;
        finished   = 0;
        prev_stall = 0;
        prev_x     = '0;
        prev_y     = '0;
        while (!finished && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (prev_stall) begin
                check({tag, ":hold_valid"}, pix_valid, 1);
                check({tag, ":hold_x"}, pix_x, prev_x);
                check({tag, ":hold_y"}, pix_y, prev_y);
            end
            if (done) begin
                finished = 1;
            end else begin
                if (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 3)
                    pix_ready = 1'b0;
                else if (ready_pct >= 100)
                    pix_ready = 1'b1;
                else
                    pix_ready = ($urandom_range(0, 99) < ready_pct);
                if (pix_valid && pix_ready) begin
                    p.x = int'(pix_x); p.y = int'(pix_y); p.last = int'(pix_last);
                    got_q.push_back(p);
                end
                prev_stall = pix_valid && !pix_ready;
                prev_x     = pix_x;
                prev_y     = pix_y;
            end
        end
        check({tag, ":done_seen"}, finished, 1);
        @(negedge clk);
        check({tag, ":done_pulse"}, done, 0);
        check({tag, ":idle_busy"}, busy, 0);
        check({tag, ":count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, ":x"}, got_q[i].x, exp_q[i].x);
            check({tag, ":y"}, got_q[i].y, exp_q[i].y);
            check({tag, ":last"}, got_q[i].last, exp_q[i].last);
        end
        if (!pen) begin
            adx = (ax2 >= ax1) ? ax2 - ax1 : ax1 - ax2;
            ady = (ay2 >= ay1) ? ay2 - ay1 : ay1 - ay2;
            check({tag, ":len_formula"}, got_q.size(), ((adx > ady) ? adx : ady) + 1);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rx1, ry1, rx2, ry2, pct;
        logic [PW-1:0] rpat;
        bit rpen;
        reset = 1'b1; start = 1'b0; pix_ready = 1'b0;
        x1 = '0; y1 = '0; x2 = '0; y2 = '0; pattern = '0; pattern_en = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", pix_valid, 0);
        check("rst_last", pix_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_x", pix_x, 0);
        check("rst_y", pix_y, 0);
        reset = 1'b0;

        run_line(100, 90, 50, 100, 8'h00, 1'b0, 100, -1, "steep_left");
        run_line(10, 50, 20, 50, 8'h00, 1'b0, 100, -1, "horiz");
        run_line(30, 10, 20, 20, 8'h00, 1'b0, 100, -1, "diag");
        run_line(0, 0, 15, 0, 8'h0F, 1'b1, 100, -1, "dash");

        // Degenerate line: exact cycle timing of pixel, done and return to idle.
        @(negedge clk);
        x1 = 16'd10; y1 = 16'd5; x2 = 16'd10; y2 = 16'd5;
        pattern_en = 1'b0; pix_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("pt_n1_busy", busy, 1);
        check("pt_n1_valid", pix_valid, 0);
        @(negedge clk);
        check("pt_n2_valid", pix_valid, 1);
        check("pt_n2_last", pix_last, 1);
        check("pt_n2_x", pix_x, 10);
        check("pt_n2_y", pix_y, 5);
        check("pt_n2_done", done, 0);
        @(negedge clk);
        check("pt_n3_done", done, 1);
        check("pt_n3_busy", busy, 1);
        check("pt_n3_valid", pix_valid, 0);
        @(negedge clk);
        check("pt_n4_busy", busy, 0);
        check("pt_n4_done", done, 0);

        run_line(0, 0, 20, 7, 8'h00, 1'b0, 100, 5, "stall");

        // Reset mid-line abandons it without a done pulse.
        @(negedge clk);
        x1 = 16'd0; y1 = 16'd0; x2 = 16'd40; y2 = 16'd0;
        pattern_en = 1'b0; pix_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("mid_valid", pix_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        check("mrst_valid", pix_valid, 0);
        check("mrst_last", pix_last, 0);
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_x", pix_x, 0);
        check("mrst_y", pix_y, 0);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_done", done, 0);
            check("post_rst_busy", busy, 0);
        end
        run_line(5, 5, 7, 5, 8'h00, 1'b0, 100, -1, "after_rst");

        run_line(65535, 65535, 65500, 65530, 8'hA5, 1'b1, 60, -1, "corner_hi");
        run_line(0, 65535, 30, 65520, 8'h00, 1'b0, 50, -1, "corner_lo");
        run_line(65535, 0, 65495, 2, 8'h3C, 1'b1, 100, -1, "corner_x");

        for (int k = 0; k < 25; k++) begin
            rx1  = $urandom_range(0, 120);
            ry1  = $urandom_range(0, 120);
            rx2  = $urandom_range(0, 120);
            ry2  = $urandom_range(0, 120);
            rpat = PW'($urandom);
            rpen = 1'($urandom);
            case ($urandom_range(0, 2))
                0:       pct = 100;
                1:       pct = 60;
                default: pct = 30;
            endcase
            run_line(rx1, ry1, rx2, ry2, rpat, rpen, pct, -1, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/line_raster.md
LINE_RASTER -- requirements
Module: line_raster

Interface
REQ-001 Parameter COORD_W, default 16: unsigned coordinate width.
REQ-002 Parameter PATTERN_W, default 8: dash-pattern length in pixels, at least 2.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a new line; sampled only in IDLE.
REQ-006 x1, y1  input  COORD_W each  start point, unsigned.
REQ-007 x2, y2  input  COORD_W each  end point, unsigned.
REQ-008 pattern  input  PATTERN_W  dash mask; bit i gates pixel index i mod PATTERN_W.
REQ-009 pattern_en  input  1  1 = apply pattern, 0 = emit every pixel.
REQ-010 pix_ready  input  1  consumer accepts the current pixel.
REQ-011 pix_valid  output  1  pix_x/pix_y/pix_last hold a valid pixel.
REQ-012 pix_x, pix_y  output  COORD_W each  current pixel coordinate.
REQ-013 pix_last  output  1  current pixel is the end point.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse after the last pixel is accepted.

Function
REQ-016 FSM states: IDLE, SETUP, RUN, DONE.
REQ-017 IDLE, start=1: latch x1, y1, x2, y2, pattern, pattern_en; go to SETUP. start in any other state is ignored.
REQ-018 SETUP (1 cycle): dx=|x2-x1|, dy=-|y2-y1|, sx=+1/-1 (x2>=x1 / else), sy likewise, err=dx+dy, cur=(x1,y1), pattern index=0; go to RUN.
REQ-019 Internal dx, dy, err and 2*err: signed, COORD_W+2 bits; no overflow for any input pair.
REQ-020 Latency: start sampled in cycle N gives busy=1 from N+1 and the earliest pix_valid in N+2.
REQ-021 Step rule (Bresenham, all octants): e2=2*err; if e2>=dy then err+=dy, x+=sx; if e2<=dx then err+=dx, y+=sy; both updates apply in the same step when both hold.
REQ-022 A pixel is emitted when pattern_en=0, or pattern[index]=1, or cur equals (x2,y2).
REQ-023 Emitted pixel: pix_valid=1 with cur; outputs stay stable while pix_valid=1 and pix_ready=0.
REQ-024 Emitted pixel accepted (pix_valid & pix_ready): step once, index=(index+1) mod PATTERN_W.
REQ-025 Suppressed pixel: pix_valid=0; step and increment index in the same cycle with no handshake.
REQ-026 pix_last=1 only when cur equals (x2,y2); the end point is always emitted.
REQ-027 Accepted pixel with pix_last=1: go to DONE; no further step.
REQ-028 DONE: done=1, busy=1, pix_valid=0 for one cycle; then IDLE.
REQ-029 Degenerate line (x1=x2, y1=y2): exactly one pixel, pix_last=1.
REQ-030 Pixel count = max(|x2-x1|, |y2-y1|)+1 before pattern suppression.
REQ-031 pix_ready is ignored while pix_valid=0.

Reset
REQ-032 reset=1 at a rising edge: state=IDLE; pix_valid, pix_last, busy, done, pix_x, pix_y all 0; internal registers 0.
REQ-033 reset takes priority over start and the handshake; a line in progress is abandoned with no done pulse.
REQ-034 The first start after reset deasserts behaves identically to a start from power-up.

Verification
REQ-035 (100,90)->(50,100), pattern_en=0, pix_ready=1 -> 51 pixels; first (100,90), last (50,100) with pix_last=1; y monotonically non-decreasing; one done pulse.
REQ-036 (10,50)->(20,50) -> 11 pixels, x=10..20, y=50; (30,10)->(20,20) -> 11 pixels, x-1 and y+1 per pixel.
REQ-037 (10,5)->(10,5) -> one pixel (10,5) with pix_last=1 in cycle N+2; done in N+3; busy low in N+4.
REQ-038 (0,0)->(15,0), pattern=8'h0F, pattern_en=1 -> 9 pixels, x=0,1,2,3,8,9,10,11,15; x=15 has pix_last=1.
REQ-039 Backpressure: pix_ready=0 for 3 cycles mid-line -> pix_valid stays 1 with pix_x/pix_y unchanged; the full pixel sequence is unchanged versus pix_ready=1.
REQ-040 reset=1 during RUN of (0,0)->(40,0) -> next cycle all outputs 0, no done pulse; a new start of (5,5)->(7,5) then gives (5,5),(6,5),(7,5).
